conv_sobel: RTL and testbench



---
 rtl/conv_pkg.sv | 19 +
 rtl/sobel_px.sv | 59 +++++
 rtl/conv_sobel.sv | 101 ++++++++++
 tb/tb_conv_sobel.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and types for the streaming Sobel edge-magnitude filter.
package conv_pkg;

  localparam int unsigned IMG_W     = 512;
  localparam int unsigned PIX_W     = 8;
  localparam int unsigned PPB       = 16;
  localparam int unsigned ROW_BEATS = IMG_W / PPB;
  localparam int unsigned PIPE      = 3;

  localparam int unsigned BEAT_W = PIX_W * PPB;
  localparam int unsigned GRAD_W = PIX_W + 3;
  localparam int unsigned COL_W  = $clog2(ROW_BEATS);
  localparam int unsigned ROW_W  = $clog2(IMG_W);

  typedef logic [PIX_W-1:0]         pix_t;
  typedef logic [BEAT_W-1:0]        beat_t;
  typedef logic signed [GRAD_W-1:0] grad_t;

endpackage

// File: rtl/sobel_px.sv
// Single-pixel Sobel kernel: gradients, |Gx|+|Gy|, then saturate and border-mask.
module sobel_px
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [PIX_W-1:0] p00,
  input  logic [PIX_W-1:0] p01,
  input  logic [PIX_W-1:0] p02,
  input  logic [PIX_W-1:0] p10,
  input  logic [PIX_W-1:0] p12,
  input  logic [PIX_W-1:0] p20,
  input  logic [PIX_W-1:0] p21,
  input  logic [PIX_W-1:0] p22,
  input  logic             border,
  output logic [PIX_W-1:0] mag
);

  grad_t             gx_c, gy_c, gx_q, gy_q;
  logic [GRAD_W-1:0] ax, ay;
  logic [GRAD_W:0]   sum_c, sum_q;
  logic              b1, b2;

  always_comb begin
    gx_c = (grad_t'(p02) + grad_t'({p12, 1'b0}) + grad_t'(p22))
         - (grad_t'(p00) + grad_t'({p10, 1'b0}) + grad_t'(p20));
    gy_c = (grad_t'(p20) + grad_t'({p21, 1'b0}) + grad_t'(p22))
         - (grad_t'(p00) + grad_t'({p01, 1'b0}) + grad_t'(p02));
    ax    = gx_q[GRAD_W-1] ? GRAD_W'(-gx_q) : GRAD_W'(gx_q);
    ay    = gy_q[GRAD_W-1] ? GRAD_W'(-gy_q) : GRAD_W'(gy_q);
    sum_c = {1'b0, ax} + {1'b0, ay};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gx_q  <= '0;
      gy_q  <= '0;
      b1    <= 1'b0;
      sum_q <= '0;
      b2    <= 1'b0;
      mag   <= '0;
    end else if (en) begin
      gx_q  <= gx_c;
      gy_q  <= gy_c;
      b1    <= border;
      sum_q <= sum_c;
      b2    <= b1;
      // any bit above the pixel width means the magnitude exceeds full scale
      if (b2)
        mag <= '0;
      else if (sum_q[GRAD_W:PIX_W] != '0)
        mag <= '1;
      else
        mag <= sum_q[PIX_W-1:0];
    end
  end

endmodule

// File: rtl/conv_sobel.sv
// Streaming 3x3 Sobel magnitude over 16-pixel beats with two row delay lines
// and a border mask derived from the window-centre position.
module conv_sobel
  import conv_pkg::*;
(
  input  logic                   s_axis_aclk,
  input  logic                   s_axis_aresetn,
  input  logic                   stall,
  input  logic [PIX_W*PPB-1:0]   s_data,
  output logic [PIX_W*PPB-1:0]   m_data
);

  localparam int unsigned EXT_W = (PPB + 2) * PIX_W;

  logic [COL_W-1:0] col, ccol;
  logic [ROW_W-1:0] row, crow;

  beat_t lb_mid [ROW_BEATS];
  beat_t lb_top [ROW_BEATS];

  beat_t bot_nxt, bot_cur, mid_nxt, mid_cur, top_nxt, top_cur;
  pix_t  bot_prv, mid_prv, top_prv;

  // Line buffers are addressed by the column-beat counter, so each read
  // returns the same beat position from one row earlier. Of the oldest beat
  // in each window row only pixel 15 is ever a neighbour, so only it is kept.
  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      col     <= '0;
      row     <= '0;
      ccol    <= '0;
      crow    <= '0;
      lb_mid  <= '{default: '0};
      lb_top  <= '{default: '0};
      bot_nxt <= '0;
      bot_cur <= '0;
      bot_prv <= '0;
      mid_nxt <= '0;
      mid_cur <= '0;
      mid_prv <= '0;
      top_nxt <= '0;
      top_cur <= '0;
      top_prv <= '0;
    end else if (!stall) begin
      col <= (col == COL_W'(ROW_BEATS - 1)) ? '0 : col + 1'b1;
      if (col == COL_W'(ROW_BEATS - 1))
        row <= (row == ROW_W'(IMG_W - 1)) ? '0 : row + 1'b1;

      // centre = incoming position minus one row and one beat
      ccol <= col - 1'b1;
      crow <= (col == '0) ? row - ROW_W'(2) : row - 1'b1;

      lb_mid[col] <= s_data;
      lb_top[col] <= lb_mid[col];

      bot_nxt <= s_data;
      bot_cur <= bot_nxt;
      bot_prv <= bot_cur[PIX_W-1:0];
      mid_nxt <= lb_mid[col];
      mid_cur <= mid_nxt;
      mid_prv <= mid_cur[PIX_W-1:0];
      top_nxt <= lb_top[col];
      top_cur <= top_nxt;
      top_prv <= top_cur[PIX_W-1:0];
    end
  end

  logic [EXT_W-1:0] ext_top, ext_mid, ext_bot;
  logic             row_edge;

  assign ext_top  = {top_prv, top_cur, top_nxt[BEAT_W-1 -: PIX_W]};
  assign ext_mid  = {mid_prv, mid_cur, mid_nxt[BEAT_W-1 -: PIX_W]};
  assign ext_bot  = {bot_prv, bot_cur, bot_nxt[BEAT_W-1 -: PIX_W]};
  assign row_edge = (crow == '0) || (crow == ROW_W'(IMG_W - 1));

  for (genvar i = 0; i < PPB; i++) begin : g_px
    localparam int unsigned L = EXT_W - i * PIX_W;
    logic border;

    assign border = row_edge
                 || (i == 0 && ccol == '0)
                 || (i == PPB - 1 && ccol == COL_W'(ROW_BEATS - 1));

    sobel_px u_px (
      .clk    (s_axis_aclk),
      .rst_n  (s_axis_aresetn),
      .en     (~stall),
      .p00    (ext_top[L-1 -: PIX_W]),
      .p01    (ext_top[L-1-PIX_W -: PIX_W]),
      .p02    (ext_top[L-1-2*PIX_W -: PIX_W]),
      .p10    (ext_mid[L-1 -: PIX_W]),
      .p12    (ext_mid[L-1-2*PIX_W -: PIX_W]),
      .p20    (ext_bot[L-1 -: PIX_W]),
      .p21    (ext_bot[L-1-PIX_W -: PIX_W]),
      .p22    (ext_bot[L-1-2*PIX_W -: PIX_W]),
      .border (border),
      .mag    (m_data[BEAT_W-1-i*PIX_W -: PIX_W])
    );
  end

endmodule

// File: tb/tb_conv_sobel.sv
// Directed bench for conv_sobel: synthetic frames with closed-form expected magnitudes.
module tb_conv_sobel;

  localparam int LAT   = 36;
  localparam int RB    = 32;
  localparam int IW    = 512;
  localparam int FRAME = IW * RB;

  logic         s_axis_aclk = 1'b0;
  logic         s_axis_aresetn;
  logic         stall;
  logic [127:0] s_data;
  logic [127:0] m_data;

  int errors = 0;
  int checks = 0;

  conv_sobel dut (
    .s_axis_aclk    (s_axis_aclk),
    .s_axis_aresetn (s_axis_aresetn),
    .stall          (stall),
    .s_data         (s_data),
    .m_data         (m_data)
  );

  always #5 s_axis_aclk = ~s_axis_aclk;

  // pattern 0: flat 0x80; 1: 10|20 split at col 256; 2: 0|5 split at row 100; 3: 0|255 at col 256
  function automatic logic [7:0] pix(input int pat, input int r, input int c);
    case (pat)
      0: return 8'h80;
      1: return (c < 256) ? 8'd10 : 8'd20;
      2: return (r < 100) ? 8'd0 : 8'd5;
      3: return (c < 256) ? 8'd0 : 8'd255;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] exp_px(input int pat, input int r, input int c);
    if (r == 0 || r == IW - 1 || c == 0 || c == IW - 1) return 8'd0;
    case (pat)
      1: return (c == 255 || c == 256) ? 8'd40 : 8'd0;
      2: return (r == 99 || r == 100) ? 8'd20 : 8'd0;
      3: return (c == 255 || c == 256) ? 8'd255 : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [127:0] in_beat(input int pat, input int t);
    logic [127:0] b;
    int r, cb;
    r  = (t / RB) % IW;
    cb = t % RB;
    b  = '0;
    for (int i = 0; i < 16; i++) b[127-8*i -: 8] = pix(pat, r, cb * 16 + i);
    return b;
  endfunction

  // expected m_data after the edge that accepted stream beat t
  function automatic logic [127:0] exp_beat(input int pat, input int t);
    logic [127:0] b;
    int k, r, cb;
    b = '0;
    if (t >= LAT) begin
      k  = t - LAT;
      r  = (k / RB) % IW;
      cb = k % RB;
      for (int i = 0; i < 16; i++) b[127-8*i -: 8] = exp_px(pat, r, cb * 16 + i);
    end
    return b;
  endfunction

  task automatic push(input logic [127:0] d, input logic st);
    s_data = d;
    stall  = st;
    @(posedge s_axis_aclk);
    #1;
  endtask

  task automatic do_reset();
    s_axis_aresetn = 1'b0;
    stall          = 1'b0;
    s_data         = '1;
    repeat (2) @(posedge s_axis_aclk);
    #1;
    s_axis_aresetn = 1'b1;
  endtask

  task automatic test_reset();
    s_axis_aresetn = 1'b0;
    stall          = 1'b1;
    s_data         = '1;
    repeat (2) @(posedge s_axis_aclk);
    #1;
    checks++;
    if (m_data !== 128'd0) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", m_data, 128'd0);
    end
    s_axis_aresetn = 1'b1;
  endtask

  // one full frame plus enough of the next to flush the last centre row
  task automatic test_frame(input int pat, input string name);
    logic [127:0] e;
    do_reset();
    for (int t = 0; t < FRAME + LAT; t++) begin
      push(in_beat(pat, t), 1'b0);
      e = exp_beat(pat, t);
      checks++;
      if (m_data !== e) begin
        errors++;
        $display("FAIL %s t=%0d got=%h exp=%h", name, t, m_data, e);
      end
    end
  endtask

  task automatic test_stall();
    logic [127:0] e, held;
    do_reset();
    for (int t = 0; t < 200; t++) begin
      if (t == 84) begin
        held = exp_beat(1, 83);
        for (int s = 0; s < 7; s++) begin
          push({$urandom, $urandom, $urandom, $urandom}, 1'b1);
          checks++;
          if (m_data !== held) begin
            errors++;
            $display("FAIL stall_hold s=%0d got=%h exp=%h", s, m_data, held);
          end
        end
      end
      push(in_beat(1, t), 1'b0);
      e = exp_beat(1, t);
      checks++;
      if (m_data !== e) begin
        errors++;
        $display("FAIL stall_resume t=%0d got=%h exp=%h", t, m_data, e);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [127:0] e;
    do_reset();
    for (int t = 0; t < 200 * RB + 10; t++) begin
      push(in_beat(1, t), 1'b0);
      e = exp_beat(1, t);
      checks++;
      if (m_data !== e) begin
        errors++;
        $display("FAIL pre_reset t=%0d got=%h exp=%h", t, m_data, e);
      end
    end
    s_axis_aresetn = 1'b0;
    push({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    checks++;
    if (m_data !== 128'd0) begin
      errors++;
      $display("FAIL midframe_reset got=%h exp=%h", m_data, 128'd0);
    end
    s_axis_aresetn = 1'b1;
    for (int t = 0; t < 120; t++) begin
      push(in_beat(3, t), 1'b0);
      e = exp_beat(3, t);
      checks++;
      if (m_data !== e) begin
        errors++;
        $display("FAIL restart t=%0d got=%h exp=%h", t, m_data, e);
      end
    end
  endtask

  initial begin
    s_axis_aresetn = 1'b1;
    stall          = 1'b0;
    s_data         = '0;
    test_reset();
    test_frame(0, "constant");
    test_frame(1, "vertical_edge");
    test_frame(2, "horizontal_edge");
    test_frame(3, "saturation");
    test_stall();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
